voxel_cmd_master: RTL and testbench
===================================

// Module: voxel_cmd_master
// PURPOSE
//  Avalon-MM master that drives the voxel GPU register slave (s1) on behalf of the host.
//  Host pushes (addr,data) register commands into a FIFO. Block issues them in order:
//  - Kick commands (0x00-0x03) are followed by a wait for irq and a status read (0x0f),
//    which clears the interrupt.
//  - Camera writes (0x10-0x1e) are issued back to back.
//  - On timeout or bad status, the GPU is forced back to IDLE.
// PARAMETERS
//  DEPTH         8      command FIFO entries; power of 2, >=2
//  TIMEOUT_BITS  16     width of irq-wait timer; timeout after 2**TIMEOUT_BITS-1 cycles
// PORTS
//  clock          in   1   clock
//  reset          in   1   reset, asynchronous, active-high
//  cmd_valid      in   1   host command valid
//  cmd_ready      out  1   FIFO can accept; push happens when cmd_valid&&cmd_ready
//  cmd_addr       in   8   GPU register address
//  cmd_data       in   32  GPU register write data
//  m0_address     out  8   to GPU s1_address
//  m0_write       out  1   to GPU s1_write
//  m0_writedata   out  32  to GPU s1_writedata
//  m0_read        out  1   to GPU s1_read
//  m0_readdata    in   32  from GPU s1_readdata; zero-latency, valid when m0_read&&!m0_waitrequest
//  m0_waitrequest in   1   from GPU s1_waitrequest
//  gpu_irq        in   1   from GPU irq (level)
//  busy           out  1   FSM not IDLE or FIFO non-empty
//  done_count     out  16  kicks completed with status 0; wraps 0xffff->0
//  err            out  1   sticky error flag
//  err_code       out  2   1=bad status, 2=timeout, 3=reserved addr; first error wins
//  err_clear      in   1   pulse: clears err/err_code next cycle (set in same cycle wins)
// BEHAVIOUR
//  Reset values:
//  - all m0_* outputs 0; busy 0; done_count 0; err 0; err_code 0.
//  - FIFO emptied; cmd_ready 1.
//  All outputs registered except cmd_ready = !full (combinational from count).
//  Full and pop in the same cycle: push still refused.
//  FSM states: S_IDLE, S_WRITE, S_WAIT, S_READ, S_FORCE, S_CLEAR.
//  - S_IDLE: if FIFO non-empty, pop head into cur_addr/cur_data.
//    - cur_addr==0x0f or >0x1e: drop it, set err code 3, stay IDLE.
//    - else -> S_WRITE.
//  - S_WRITE: m0_write=1, m0_address=cur_addr, m0_writedata=cur_data, held until !m0_waitrequest.
//    - After acceptance: addr<=0x03 -> S_WAIT with timer=0; else -> S_IDLE.
//  - S_WAIT: gpu_irq=1 -> S_READ.
//    - else timer++; at timer all-ones -> set err code 2 -> S_FORCE.
//  - S_READ: m0_read=1, m0_address=0x0f; on !m0_waitrequest sample m0_readdata.
//    - ==0: done_count++ -> S_IDLE.
//    - else: set err code 1 -> S_FORCE.
//  - S_FORCE: write 0x0f data 0 (drives GPU to ERROR from any state) -> S_CLEAR.
//  - S_CLEAR: write 0x0f data 1 (ERROR->IDLE) -> S_IDLE.
//  Abort does not flush the FIFO; remaining commands continue to issue.
//  Latency:
//  - camera cmd: pop cycle N, m0_write high at N+1 (waitrequest 0); one write per 2 cycles.
//  - kick: m0_write at N+1; irq at cycle M -> m0_read at M+1.
//  m0_read and m0_write are never high together; a new kick is never issued before
//  the prior kick's status read or abort completes.
//  Reset mid-transfer: FSM, FIFO and counters clear at once. The GPU is reset separately.
// STRUCTURE
//  gpu package additions:
//  - register-address localparams GPU_REG_RASTERIZE..GPU_REG_POSITION (0x00-0x03),
//    GPU_REG_STATUS (0x0f), GPU_REG_CAM_FIRST/LAST (0x10/0x1e);
//  - typedef struct packed {logic [7:0] addr; logic [31:0] data;} gpu_cmd_t;
//  - enum gpu_cmd_err_e {ERR_NONE, ERR_STATUS, ERR_TIMEOUT, ERR_ADDR}.
//  Sub-module cmd_fifo #(WIDTH=40, DEPTH):
//  - synchronous FIFO with push/pop/full/empty/count; pointers wrap at DEPTH.
// TESTING
//  Memory-mapped reference model of the GPU register slave (s1 port behaviour) as DUT partner.
//  1. Push camera writes 0x10=5, 0x11=7, 0x12=-3: three m0_write pulses 2 cycles apart;
//     model cam.pos = (5,7,-3); done_count stays 0.
//  2. Push 0x00=0x12345678; model raises irq 20 cycles later:
//     m0_read at 0x0f the cycle after irq, readdata 0; done_count 1; irq drops; busy 0.
//  3. Fill FIFO with DEPTH cmds while model never raises irq: cmd_ready 0 at DEPTH;
//     push with cmd_valid refused; first kick times out after 65535 cycles;
//     err=1, code 2; 0x0f writes with data 0 then 1; model ends IDLE; queue resumes.
//  4. Push addr 0x0f and 0x20: both dropped, no m0 traffic, err code 3;
//     err_clear pulse -> err 0 next cycle.
//  5. Model holds m0_waitrequest 3 cycles on a write: m0_address/m0_writedata stable,
//     single accepted write.
//  6. Assert reset during S_WAIT: all outputs return to reset values; cmd_ready 1;
//     done_count 0; no further m0 traffic.

Source files
------------

// File: rtl/voxel_cmd_master_pkg.sv
// Shared definitions for the voxel GPU command master: register map,
// command record, error codes and FSM states.
package voxel_cmd_master_pkg;

  localparam logic [7:0] GPU_REG_RASTERIZE = 8'h00;
  localparam logic [7:0] GPU_REG_KICK_1    = 8'h01;
  localparam logic [7:0] GPU_REG_KICK_2    = 8'h02;
  localparam logic [7:0] GPU_REG_POSITION  = 8'h03;
  localparam logic [7:0] GPU_REG_STATUS    = 8'h0f;
  localparam logic [7:0] GPU_REG_CAM_FIRST = 8'h10;
  localparam logic [7:0] GPU_REG_CAM_LAST  = 8'h1e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } gpu_cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STATUS  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ADDR    = 2'd3
  } gpu_cmd_err_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_FORCE = 3'd4,
    S_CLEAR = 3'd5
  } cmd_state_e;

  function automatic logic is_reserved_addr(input logic [7:0] addr);
    return (addr == GPU_REG_STATUS) || (addr > GPU_REG_CAM_LAST);
  endfunction

  function automatic logic is_kick_addr(input logic [7:0] addr);
    return addr <= GPU_REG_POSITION;
  endfunction

endpackage

// File: rtl/voxel_cmd_master_cmd_fifo.sv
// Synchronous command FIFO; a push while full is dropped even if a pop
// happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/voxel_cmd_master.sv
// Avalon-MM master replaying queued host register commands into the voxel GPU,
// waiting on irq after kicks and recovering the GPU on timeout or bad status.
module voxel_cmd_master
  import voxel_cmd_master_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [7:0]  m0_address,
  output logic        m0_write,
  output logic [31:0] m0_writedata,
  output logic        m0_read,
  input  logic [31:0] m0_readdata,
  input  logic        m0_waitrequest,
  input  logic        gpu_irq,
  output logic        busy,
  output logic [15:0] done_count,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        err_clear
);

  // Last timer value before expiry: the wait lasts 2**TIMEOUT_BITS-1 cycles.
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = {TIMEOUT_BITS{1'b1}} - TIMEOUT_BITS'(1);

  cmd_state_e                 state_r;
  logic [7:0]                 cur_addr_r;
  logic [TIMEOUT_BITS-1:0]    timer_r;
  gpu_cmd_t                   push_cmd_s;
  gpu_cmd_t                   head_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [$clog2(DEPTH):0]     fifo_count_s;
  logic                       err_set_s;
  gpu_cmd_err_e               err_kind_s;

  assign push_cmd_s = '{addr: cmd_addr, data: cmd_data};
  assign cmd_ready  = !fifo_full_s;
  assign push_s     = cmd_valid && !fifo_full_s;
  assign pop_s      = (state_r == S_IDLE) && !fifo_empty_s;

  cmd_fifo #(.WIDTH($bits(gpu_cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_cmd_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Error events raised by the current state this cycle.
  always_comb begin
    err_set_s  = 1'b0;
    err_kind_s = ERR_NONE;
    case (state_r)
      S_IDLE: begin
        if (pop_s && is_reserved_addr(head_s.addr)) begin
          err_set_s  = 1'b1;
          err_kind_s = ERR_ADDR;
        end else begin
          err_set_s  = 1'b0;
          err_kind_s = ERR_NONE;
        end
      end
      S_WAIT: begin
        if (!gpu_irq && (timer_r == TIMER_LAST)) begin
          err_set_s  = 1'b1;
          err_kind_s = ERR_TIMEOUT;
        end else begin
          err_set_s  = 1'b0;
          err_kind_s = ERR_NONE;
        end
      end
      S_READ: begin
        if (!m0_waitrequest && (m0_readdata != 32'd0)) begin
          err_set_s  = 1'b1;
          err_kind_s = ERR_STATUS;
        end else begin
          err_set_s  = 1'b0;
          err_kind_s = ERR_NONE;
        end
      end
      default: begin
        err_set_s  = 1'b0;
        err_kind_s = ERR_NONE;
      end
    endcase
  end

  // Command sequencer with registered bus, status and error outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cur_addr_r   <= 8'h00;
      timer_r      <= '0;
      m0_address   <= 8'h00;
      m0_write     <= 1'b0;
      m0_writedata <= 32'h0000_0000;
      m0_read      <= 1'b0;
      busy         <= 1'b0;
      done_count   <= 16'h0000;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      // A new error beats a simultaneous clear; otherwise the first error sticks.
      if (err_set_s && (!err || err_clear)) begin
        err      <= 1'b1;
        err_code <= err_kind_s;
      end else if (err_clear) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      busy <= (state_r != S_IDLE) || (fifo_count_s != '0) || push_s;

      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            cur_addr_r <= head_s.addr;
            if (!is_reserved_addr(head_s.addr)) begin
              state_r      <= S_WRITE;
              m0_write     <= 1'b1;
              m0_address   <= head_s.addr;
              m0_writedata <= head_s.data;
            end
          end
        end
        S_WRITE: begin
          if (!m0_waitrequest) begin
            m0_write <= 1'b0;
            if (is_kick_addr(cur_addr_r)) begin
              state_r <= S_WAIT;
              timer_r <= '0;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (gpu_irq) begin
            state_r    <= S_READ;
            m0_read    <= 1'b1;
            m0_address <= GPU_REG_STATUS;
          end else if (timer_r == TIMER_LAST) begin
            state_r      <= S_FORCE;
            m0_write     <= 1'b1;
            m0_address   <= GPU_REG_STATUS;
            m0_writedata <= 32'h0000_0000;
          end else begin
            timer_r <= timer_r + TIMEOUT_BITS'(1);
          end
        end
        S_READ: begin
          if (!m0_waitrequest) begin
            m0_read <= 1'b0;
            if (m0_readdata == 32'd0) begin
              done_count <= done_count + 16'd1;
              state_r    <= S_IDLE;
            end else begin
              state_r      <= S_FORCE;
              m0_write     <= 1'b1;
              m0_address   <= GPU_REG_STATUS;
              m0_writedata <= 32'h0000_0000;
            end
          end
        end
        S_FORCE: begin
          if (!m0_waitrequest) begin
            m0_writedata <= 32'h0000_0001;
            state_r      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!m0_waitrequest) begin
            m0_write <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          m0_write <= 1'b0;
          m0_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_cmd_master.sv
// Scoreboard bench for voxel_cmd_master with a behavioural GPU register slave
// as bus partner and a command-level model predicting the bus traffic.
module tb_voxel_cmd_master;
  import voxel_cmd_master_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 65535;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  m0_address;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_read;
  logic [31:0] m0_readdata;
  logic        m0_waitrequest;
  logic        gpu_irq;
  logic        busy;
  logic [15:0] done_count;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clear;

  voxel_cmd_master #(.DEPTH(DEPTH), .TIMEOUT_BITS(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .m0_address(m0_address),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .gpu_irq(gpu_irq),
    .busy(busy), .done_count(done_count), .err(err), .err_code(err_code),
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {bit wr; logic [7:0] addr; logic [31:0] data;} txn_t;
  typedef struct {int delay; logic [31:0] status;} plan_t;

  txn_t  exp_q[$];
  plan_t plan_q[$];
  int    acc_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    ncyc    = 0;
  int    done_exp = 0;
  bit    err_exp  = 1'b0;
  int    code_exp = 0;

  // GPU slave model state
  int          gstate = 0;   // 0 idle, 1 busy, 2 error
  logic [31:0] cam [0:255];
  logic [31:0] status_reg = 32'h0;
  int          countdown = -1;
  bit          irq_n = 1'b0;
  int          stall_cnt = 0;
  bit          rand_stall = 1'b0;

  // Monitor observations
  int stall_seen = 0, kick_acc_cyc = 0, force_cyc = 0;
  bit force_seen = 1'b0;
  int irq_rise = -1, read_rise = -1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void set_err(input int c);
    if (!err_exp) begin
      err_exp  = 1'b1;
      code_exp = c;
    end
  endfunction

  // Reference model: bus traffic and status implied by one host command.
  function automatic void predict(input logic [7:0] a, input logic [31:0] d,
                                  input int delay, input logic [31:0] st);
    if (a == 8'h0f || a > 8'h1e) begin
      set_err(3);
    end else begin
      exp_q.push_back('{1'b1, a, d});
      if (a <= 8'h03) begin
        plan_q.push_back('{delay, st});
        if (delay >= 0) exp_q.push_back('{1'b0, 8'h0f, 32'h0});
        if (delay >= 0 && st == 32'h0) begin
          done_exp++;
        end else if (delay >= 0 || delay < 0) begin
          set_err(delay < 0 ? 2 : 1);
          exp_q.push_back('{1'b1, 8'h0f, 32'h0});
          exp_q.push_back('{1'b1, 8'h0f, 32'h1});
        end
      end
    end
  endfunction

  function automatic void gpu_write(input logic [7:0] a, input logic [31:0] d);
    plan_t p;
    if (a <= 8'h03) begin
      p = (plan_q.size() > 0) ? plan_q.pop_front() : '{-1, 32'h0};
      gstate     = 1;
      countdown  = p.delay;
      status_reg = p.status;
    end else if (a >= GPU_REG_CAM_FIRST && a <= GPU_REG_CAM_LAST) begin
      cam[a] = d;
    end else if (a == 8'h0f) begin
      if (d == 32'h0) begin
        gstate = 2; countdown = -1; irq_n = 1'b0;
      end else if (d == 32'h1 && gstate == 2) begin
        gstate = 0;
      end
    end
  endfunction

  // GPU s1 slave model: observes mid-cycle, drives just after the rising edge.
  initial begin
    bit wr_n;
    m0_waitrequest = 1'b0; gpu_irq = 1'b0; m0_readdata = 32'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        gstate = 0; countdown = -1; irq_n = 1'b0; status_reg = 32'h0;
      end else begin
        if (countdown > 1) countdown--;
        else if (countdown == 1) begin irq_n = 1'b1; countdown = -1; end
        if (m0_write && !m0_waitrequest) gpu_write(m0_address, m0_writedata);
        if (m0_read && !m0_waitrequest && m0_address == 8'h0f) begin
          irq_n = 1'b0;
          if (gstate == 1) gstate = 0;
        end
        if (stall_cnt > 0 && m0_write && m0_waitrequest) stall_cnt--;
      end
      wr_n = (stall_cnt > 0) || (rand_stall && $urandom_range(0, 3) == 0);
      @(posedge clock); #1;
      m0_waitrequest = wr_n; gpu_irq = irq_n; m0_readdata = status_reg;
    end
  end

  // Bus monitor: pops the expected queue on every accepted transfer.
  initial begin
    txn_t e;
    bit hold_v = 1'b0, hold_wr, hold_rd, irq_prev = 1'b0, read_prev = 1'b0;
    logic [7:0] hold_a; logic [31:0] hold_d;
    forever begin
      @(negedge clock);
      ncyc++;
      if (!reset) begin
        check("rw_exclusive", m0_write & m0_read, 1'b0);
        if (hold_v) begin
          check("hold_write", m0_write, hold_wr);
          check("hold_read", m0_read, hold_rd);
          check("hold_addr", m0_address, hold_a);
          check("hold_data", m0_writedata, hold_d);
        end
        hold_v = (m0_write || m0_read) && m0_waitrequest;
        if (hold_v) stall_seen++;
        hold_wr = m0_write; hold_rd = m0_read; hold_a = m0_address; hold_d = m0_writedata;
        if ((m0_write || m0_read) && !m0_waitrequest) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_txn: got wr=%0d addr=%0h data=%0h expected none",
                     m0_write, m0_address, m0_writedata);
          end else begin
            e = exp_q.pop_front();
            check("txn_kind", m0_write, e.wr);
            check("txn_addr", m0_address, e.addr);
            if (e.wr) check("txn_data", m0_writedata, e.data);
          end
          if (m0_write) acc_q.push_back(ncyc);
          if (m0_write && m0_address <= 8'h03) kick_acc_cyc = ncyc;
        end
        if (m0_write && m0_address == 8'h0f && m0_writedata == 32'h0 && !force_seen) begin
          force_seen = 1'b1; force_cyc = ncyc;
        end
        if (gpu_irq && !irq_prev) irq_rise = ncyc;
        if (m0_read && !read_prev) read_rise = ncyc;
      end else begin
        hold_v = 1'b0;
      end
      irq_prev = gpu_irq; read_prev = m0_read;
    end
  end

  // Host driver: called just after a rising edge, returns just after the push edge.
  task automatic push_cmd(input logic [7:0] a, input logic [31:0] d,
                          input int delay, input logic [31:0] st);
    int guard = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    do begin @(negedge clock); guard++; end while (!cmd_ready && guard < 100000);
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: got cmd_ready 0 expected 1");
    end else begin
      predict(a, d, delay, st);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0, guard = 0;
    while (quiet < 3 && guard < 100000) begin
      @(negedge clock); guard++;
      quiet = (!busy && exp_q.size() == 0 && !m0_write && !m0_read) ? quiet + 1 : 0;
    end
    check("idle_reached", quiet >= 3, 1'b1);
  endtask

  task automatic check_status();
    check("done_count", done_count, done_exp[15:0]);
    check("err", err, err_exp);
    check("err_code", err_code, code_exp[1:0]);
  endtask

  task automatic check_reset_vals();
    check("rst_m0_write", m0_write, 1'b0);
    check("rst_m0_read", m0_read, 1'b0);
    check("rst_m0_address", m0_address, 8'h00);
    check("rst_m0_writedata", m0_writedata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_count", done_count, 16'h0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 2'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic clear_err();
    @(posedge clock); #1 err_clear = 1'b1;
    @(posedge clock); #1 err_clear = 1'b0;
    err_exp = 1'b0; code_exp = 0;
    @(negedge clock);
    check("err_cleared", err, 1'b0);
    check("err_code_cleared", err_code, 2'd0);
  endtask

  initial begin
    #5_000_000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int guard;
    logic [7:0] a;
    int r;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_data = 32'h0; err_clear = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    @(posedge clock); #1 reset = 1'b0;

    // 1: camera writes back to back
    acc_q.delete();
    push_cmd(8'h10, 32'd5, 0, 32'h0);
    push_cmd(8'h11, 32'd7, 0, 32'h0);
    push_cmd(8'h12, 32'hffff_fffd, 0, 32'h0);
    wait_idle();
    check("cam_writes", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("cam_spacing_1", acc_q[1] - acc_q[0], 2);
      check("cam_spacing_2", acc_q[2] - acc_q[1], 2);
    end
    check("cam_x", cam[8'h10], 32'd5);
    check("cam_y", cam[8'h11], 32'd7);
    check("cam_z", cam[8'h12], 32'hffff_fffd);
    check_status();

    // 2: kick with irq after 20 cycles
    @(posedge clock); #1;
    irq_rise = -1; read_rise = -1;
    push_cmd(8'h00, 32'h1234_5678, 20, 32'h0);
    wait_idle();
    check("read_after_irq", read_rise - irq_rise, 1);
    check("irq_dropped", gpu_irq, 1'b0);
    check_status();

    // 3: fill the FIFO behind a kick that never completes
    @(posedge clock); #1;
    force_seen = 1'b0;
    push_cmd(8'h01, 32'h0000_00aa, -1, 32'h0);
    for (int i = 0; i < DEPTH; i++) push_cmd(8'h10 + 8'(i), 32'(i) + 32'h100, 0, 32'h0);
    cmd_valid = 1'b1; cmd_addr = 8'h1e; cmd_data = 32'hdead_beef;
    repeat (4) begin
      @(negedge clock);
      check("full_refuses", cmd_ready, 1'b0);
    end
    @(posedge clock); #1 cmd_valid = 1'b0;
    guard = 0;
    while (!err && guard < 70000) begin @(negedge clock); guard++; end
    wait_idle();
    check("timeout_cycles", force_cyc - kick_acc_cyc, TIMEOUT + 1);
    check("gpu_back_idle", gstate, 0);
    check_status();

    // 4: reserved addresses are dropped with error 3
    clear_err();
    @(posedge clock); #1;
    push_cmd(8'h0f, 32'h1, 0, 32'h0);
    push_cmd(8'h20, 32'h2, 0, 32'h0);
    wait_idle();
    check_status();
    clear_err();

    // 5: stalled write holds its address and data
    @(posedge clock); #1;
    stall_cnt = 3; stall_seen = 0;
    push_cmd(8'h13, 32'h0000_55aa, 0, 32'h0);
    wait_idle();
    check("stall_cycles", stall_seen, 3);
    check("stalled_write", cam[8'h13], 32'h0000_55aa);

    // Randomised mix with random waitrequest
    @(posedge clock); #1;
    rand_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        a = ($urandom_range(0, 1) == 0) ? 8'h0f : 8'(8'h1f + $urandom_range(0, 200));
        push_cmd(a, $urandom, 0, 32'h0);
      end else if (r < 35) begin
        push_cmd(8'($urandom_range(0, 3)), $urandom, $urandom_range(1, 30),
                 ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0);
      end else begin
        push_cmd(8'($urandom_range(8'h10, 8'h1e)), $urandom, 0, 32'h0);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    wait_idle();
    rand_stall = 1'b0;
    check_status();

    // 6: reset while waiting for irq
    @(posedge clock); #1;
    push_cmd(8'h02, 32'h0000_0042, -1, 32'h0);
    repeat (10) @(negedge clock);
    check("in_wait_busy", busy, 1'b1);
    @(posedge clock); #1 reset = 1'b1;
    exp_q.delete(); plan_q.delete();
    done_exp = 0; err_exp = 1'b0; code_exp = 0;
    @(negedge clock);
    check_reset_vals();
    @(posedge clock); #1 reset = 1'b0;
    repeat (50) @(negedge clock);
    check_status();
    check("no_traffic_after_reset", m0_write | m0_read, 1'b0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
